// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider and its phase meter.
// Nominal divider timing, measurement FSM states and a helper for tolerance checks.
package clk_div_pkg;

    localparam int CLK_DIV_WIDTH = 10;
    localparam int CLK_DIV_N     = 950;
    localparam int CLK_DIV_D     = 240;

    typedef enum logic {
        IDLE,
        MEAS
    } meas_state_t;

    // Larger minus smaller, so the difference never wraps.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clk_phase_meter_edge_sync.sv
// Two-flop synchronizer followed by a registered edge detector.
// Edges are masked until the pipeline holds real samples, so a level present at reset is not an edge.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe;
    logic [2:0] arm;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
            arm  <= '0;
        end else begin
            pipe <= {pipe[1:0], d};
            arm  <= {arm[1:0], 1'b1};
        end
    end

    assign rise = arm[2] &  pipe[1] & ~pipe[2];
    assign fall = arm[2] & ~pipe[1] &  pipe[2];

endmodule

// File: rtl/clk_phase_meter.sv
// Measures period, high time and rise-to-rise delay of a divided clock pair in clk cycles
// and raises a lock qualifier after LOCK_CNT consecutive in-tolerance measurements.
module clk_phase_meter
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = CLK_DIV_WIDTH,
    parameter int N_NOM    = CLK_DIV_N,
    parameter int D_NOM    = CLK_DIV_D,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clk,
    input  logic             i_clkd,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic [WIDTH-1:0] o_delay,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_locked
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam int LW = $clog2(LOCK_CNT + 1);

    logic             clk_rise;
    logic             clk_fall;
    logic             clkd_rise;
    logic             clkd_fall_unused;

    meas_state_t      state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] high_cap;
    logic [WIDTH-1:0] dly_cap;
    logic [1:0]       fall_n;
    logic [1:0]       drise_n;
    logic [LW-1:0]    lock_n;
    logic             period_good;
    logic             in_tol;

    edge_sync u_sync_clk (
        .clk  (clk),
        .rst  (rst),
        .d    (i_clk),
        .rise (clk_rise),
        .fall (clk_fall)
    );

    edge_sync u_sync_clkd (
        .clk  (clk),
        .rst  (rst),
        .d    (i_clkd),
        .rise (clkd_rise),
        .fall (clkd_fall_unused)
    );

    // Counts of 2 in fall_n/drise_n act as the sticky glitch flag.
    assign cnt_inc     = cnt + 1'b1;
    assign period_good = (fall_n == 2'd1) && (drise_n == 2'd1);
    assign in_tol      = (abs_diff(32'(cnt_inc), 32'(N_NOM)) <= 32'(TOL)) &&
                         (abs_diff(32'(dly_cap), 32'(D_NOM)) <= 32'(TOL));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            high_cap <= '0;
            dly_cap  <= '0;
            fall_n   <= '0;
            drise_n  <= '0;
            lock_n   <= '0;
            o_period <= '0;
            o_high   <= '0;
            o_delay  <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_locked <= (lock_n == LW'(LOCK_CNT));

            if (clk_rise)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt_inc;

            case (state)
                IDLE: begin
                    if (clk_rise) begin
                        state   <= MEAS;
                        fall_n  <= '0;
                        drise_n <= {1'b0, clkd_rise};
                        if (clkd_rise)
                            dly_cap <= '0;
                    end
                end

                MEAS: begin
                    if (clk_rise) begin
                        if (period_good) begin
                            o_valid  <= 1'b1;
                            o_period <= cnt_inc;
                            o_high   <= high_cap;
                            o_delay  <= dly_cap;
                            if (!in_tol)
                                lock_n <= '0;
                            else if (lock_n != LW'(LOCK_CNT))
                                lock_n <= lock_n + 1'b1;
                        end else begin
                            o_err  <= 1'b1;
                            lock_n <= '0;
                        end
                        // A delayed rise coincident with the primary rise belongs to the new period.
                        fall_n  <= '0;
                        drise_n <= {1'b0, clkd_rise};
                        if (clkd_rise)
                            dly_cap <= '0;
                    end else if (cnt == CNT_MAX - 1'b1) begin
                        o_err  <= 1'b1;
                        lock_n <= '0;
                        state  <= IDLE;
                    end else begin
                        if (clk_fall) begin
                            high_cap <= cnt_inc;
                            if (fall_n != 2'd2)
                                fall_n <= fall_n + 1'b1;
                        end
                        if (clkd_rise) begin
                            dly_cap <= cnt_inc;
                            if (drise_n != 2'd2)
                                drise_n <= drise_n + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_phase_meter.sv
// Scoreboard bench for clk_phase_meter: an event-level model of the driven waveforms
// pushes expected results, and a monitor pops them on every o_valid/o_err pulse.
module tb_clk_phase_meter;

    localparam int N_NOM = 950;
    localparam int D_NOM = 240;
    localparam int TOL   = 2;
    localparam int LOCK  = 4;

    typedef struct {
        logic       valid;
        logic       tmo;
        logic [9:0] per;
        logic [9:0] hi;
        logic [9:0] dl;
        logic       locked;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_clk = 1'b0;
    logic       i_clkd = 1'b0;
    logic [9:0] o_period;
    logic [9:0] o_high;
    logic [9:0] o_delay;
    logic       o_valid;
    logic       o_err;
    logic       o_locked;

    clk_phase_meter dut (
        .clk      (clk),
        .rst      (rst),
        .i_clk    (i_clk),
        .i_clkd   (i_clkd),
        .o_period (o_period),
        .o_high   (o_high),
        .o_delay  (o_delay),
        .o_valid  (o_valid),
        .o_err    (o_err),
        .o_locked (o_locked)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    item_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waveform history for the delayed copy.
    logic hist [1024];
    int   t   = 0;
    int   dly = D_NOM;

    // Reference model state.
    logic m_pc = 1'b0, m_pcd = 1'b0, m_meas = 1'b0;
    int   m_arm = 0, m_age = 0, m_falls = 0, m_dris = 0, m_hcap = 0, m_dcap = 0, m_lk = 0;
    logic [9:0] m_per = '0, m_hi = '0, m_dl = '0;

    // Monitor state.
    int   cyc = 0, last_evt = 0, err_seen = 0;
    logic lock_pend = 1'b0, lock_exp = 1'b0;
    item_t mon_it;

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic push_item(input logic valid, input logic tmo);
        item_t it;
        it.valid  = valid;
        it.tmo    = tmo;
        it.per    = m_per;
        it.hi     = m_hi;
        it.dl     = m_dl;
        it.locked = (m_lk == LOCK);
        sb.push_back(it);
    endtask

    task automatic model_step(input logic c, input logic cd, input logic r);
        logic rise, fall, drise;
        if (r) begin
            m_meas = 1'b0; m_lk = 0; m_arm = 0;
            m_per = '0; m_hi = '0; m_dl = '0;
            sb.delete();
            lock_pend = 1'b0;
            m_pc = c; m_pcd = cd;
            return;
        end
        if (m_arm == 0) begin
            m_arm = 1; m_pc = c; m_pcd = cd;
            return;
        end
        rise  = c && !m_pc;
        fall  = !c && m_pc;
        drise = cd && !m_pcd;
        m_pc  = c;
        m_pcd = cd;
        if (m_meas)
            m_age++;
        if (rise) begin
            if (m_meas) begin
                if (m_falls == 1 && m_dris == 1) begin
                    m_per = 10'(m_age); m_hi = 10'(m_hcap); m_dl = 10'(m_dcap);
                    if (adiff(m_age, N_NOM) <= TOL && adiff(m_dcap, D_NOM) <= TOL)
                        m_lk = (m_lk < LOCK) ? m_lk + 1 : m_lk;
                    else
                        m_lk = 0;
                    push_item(1'b1, 1'b0);
                end else begin
                    m_lk = 0;
                    push_item(1'b0, 1'b0);
                end
            end
            m_meas = 1'b1; m_age = 0; m_falls = 0;
            m_dris = drise ? 1 : 0;
            if (drise) m_dcap = 0;
        end else if (m_meas) begin
            if (m_age == 1023) begin
                m_lk = 0;
                push_item(1'b0, 1'b1);
                m_meas = 1'b0;
            end else begin
                if (fall) begin
                    if (m_falls == 0) m_hcap = m_age;
                    if (m_falls < 2) m_falls++;
                end
                if (drise) begin
                    if (m_dris == 0) m_dcap = m_age;
                    if (m_dris < 2) m_dris++;
                end
            end
        end
    endtask

    task automatic step(input logic c, input logic r);
        logic cd;
        @(negedge clk);
        hist[t % 1024] = c;
        cd = (dly == 0) ? c : ((t >= dly) ? hist[(t - dly) % 1024] : 1'b0);
        t++;
        rst    = r;
        i_clk  = c;
        i_clkd = cd;
        model_step(c, cd, r);
    endtask

    task automatic run_period(input int n, input int hi, input int g);
        for (int k = 0; k < n; k++)
            step((k < hi) && !(g >= 0 && k >= g && k < g + 3), 1'b0);
    endtask

    task automatic do_reset(input logic c);
        step(c, 1'b1);
        @(posedge clk);
        #1;
        check("rst_period", o_period, 0);
        check("rst_high",   o_high,   0);
        check("rst_delay",  o_delay,  0);
        check("rst_valid",  o_valid,  0);
        check("rst_err",    o_err,    0);
        check("rst_locked", o_locked, 0);
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (lock_pend) begin
            check("locked_after_evt", o_locked, lock_exp);
            lock_pend = 1'b0;
        end
        if (o_valid || o_err) begin
            check("valid_err_excl", o_valid & o_err, 0);
            if (o_err) err_seen++;
            if (sb.size() == 0) begin
                check("unexpected_evt", {o_valid, o_err}, 0);
            end else begin
                mon_it = sb.pop_front();
                check("evt_kind", o_valid, mon_it.valid);
                check("period",   o_period, mon_it.per);
                check("high",     o_high,   mon_it.hi);
                check("delay",    o_delay,  mon_it.dl);
                if (mon_it.tmo)
                    check("timeout_gap", cyc - last_evt, 1023);
                lock_exp  = mon_it.locked;
                lock_pend = 1'b1;
            end
            last_evt = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal divider timing: lock after the fifth rise.
        dly = D_NOM;
        do_reset(1'b0);
        repeat (4) step(1'b0, 1'b0);
        repeat (7) run_period(950, 475, -1);
        check("nom_locked", o_locked, 1);
        check("nom_no_err", err_seen, 0);

        // Delayed clock identical to primary: delay reads 0, never locks.
        dly = 0;
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (6) run_period(950, 475, -1);
        check("d0_unlocked", o_locked, 0);

        // Off-nominal period, then within tolerance.
        dly = D_NOM;
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (4) run_period(960, 480, -1);
        check("off960_unlocked", o_locked, 0);
        repeat (6) run_period(951, 475, -1);
        check("off951_locked", o_locked, 1);

        // Short low pulse inside the high phase after lock.
        run_period(950, 475, 100);
        check("glitch_unlocked", o_locked, 0);
        repeat (6) run_period(950, 475, -1);
        check("glitch_relocked", o_locked, 1);

        // Primary clock stalls low: timeout, then restart.
        repeat (1100) step(1'b0, 1'b0);
        check("tmo_unlocked", o_locked, 0);
        repeat (3) run_period(950, 475, -1);

        // Reset 300 cycles into a period.
        repeat (2) run_period(950, 475, -1);
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0);
        do_reset(1'b1);
        for (int k = 301; k < 950; k++) step(k < 475, 1'b0);
        repeat (3) run_period(950, 475, -1);

        repeat (20) step(1'b0, 1'b0);
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
